sparse_systolic_tile: RTL and testbench
=======================================

Name: sparse_systolic_tile

Overview:
Weight-stationary, sparse-aware MAC tile of N_ROWS x N_COLS PEs. It generalises the team's free-running sparse array with a sequencer and three handshaked interfaces.
- Valid/ready handshakes on weight load, activation stream and result drain.
- Explicit accumulator clear on start.
- Zero-block skipping at the stream level.
- Row-serial result readout.

It sits between the sparse scheduler and act/wgt buffers upstream, and the output/requant stage downstream.

Parameters:
N_ROWS, 16, PE rows (>=2); one activation lane per row
N_COLS, 16, PE columns (>=2); one weight lane and one result lane per column
DATA_W, 8, signed activation/weight width
ACC_W, 32, signed accumulator width (>= 2*DATA_W)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  pulse; honoured only in IDLE
wgt_valid  in  1  weight row beat valid
wgt_ready  out  1  high only in LOAD
wgt_data  in  N_COLS*DATA_W  lane c = W[row][c]
act_valid  in  1  activation beat valid
act_ready  out  1  high only in COMPUTE
act_data  in  N_ROWS*DATA_W  lane r = a_r
act_zero  in  1  beat is an all-zero block; skip
act_last  in  1  final beat of stream
res_valid  out  1  result row valid
res_ready  in  1  downstream accepts row
res_data  out  N_COLS*ACC_W  lane c = acc[res_row][c]
res_row  out  max(1,$clog2(N_ROWS))  index of row on res_data
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after last row accepted

Behaviour:
- Reset (any state, any time):
  - State goes to IDLE.
  - All accumulators, weights, activation pipeline registers and counters reset to 0.
  - All outputs reset to 0.
  - A reset mid-operation abandons the job; nothing survives it.
- IDLE:
  - wgt_ready = act_ready = res_valid = 0.
  - start=1 → LOAD; on the same edge, all accumulators clear to 0 and load_ptr = 0.
  - start in any other state is ignored.
- LOAD:
  - wgt_ready = 1.
  - Each wgt handshake writes wgt_data into weight row load_ptr, then load_ptr++.
  - The handshake at load_ptr == N_ROWS-1 → COMPUTE, with load_ptr wrapping to 0.
  - Weights persist until overwritten by a later LOAD.
- COMPUTE:
  - act_ready = 1.
  - A handshake with act_zero=0 injects act_data into the row pipelines.
  - For a handshake at edge E, PE(r,c) updates at edge E+1+c: acc[r][c] += sext(a_r * W[r][c]).
  - The product is a full signed 2*DATA_W result, sign-extended to ACC_W.
  - A handshake with act_zero=1 injects nothing; the data is ignored and the pipeline carries a bubble.
  - Cycles without a handshake carry bubbles.
  - A handshake with act_last=1 (act_zero of either value) → FLUSH.
- FLUSH:
  - act_ready = 0.
  - Counts exactly N_COLS cycles, then → DRAIN.
  - The last injected beat reaches column N_COLS-1 on the final FLUSH edge.
- DRAIN:
  - res_valid = 1 and res_row starts at 0; res_data = acc[res_row][*].
  - Each res handshake advances res_row.
  - The handshake on row N_ROWS-1 → IDLE with done=1 for the following cycle.
  - res_data and res_row are held stable while res_valid & !res_ready.
  - res_data = 0 outside DRAIN.
- Accumulators are preserved after the job until the next start.
- Arithmetic: wraps modulo 2^ACC_W unless the optional feature is enabled.

Optional Feature:
Macro SPARSE_TILE_ACC_SAT_EN.
- Defined: each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1], with overflow detected on the ACC_W+1-bit sum.
- Undefined: two's-complement wrap, and no saturation logic is present.

Test Plan:
All scenarios use N_ROWS = N_COLS = 4, DATA_W = 8, ACC_W = 32 unless stated.
1. Basic accumulate: start, load 4 rows of W=1, 3 beats of a_r=2 (last on beat 3) → FLUSH lasts 4 cycles; DRAIN gives rows 0..3 with every lane = 6; done pulses once; busy falls with done.
2. Zero skip: W[r][c]=r+c; 5 beats of a_r=3 with act_zero=1 on beats 2 and 4 (data 7) → acc[r][c] = 9*(r+c), e.g. acc[3][3] = 54.
3. Drain backpressure: toggle res_ready 1-0-0-1 pseudo-randomly → res_data/res_row stable while stalled; rows arrive in order 0,1,2,3 exactly once.
4. Overflow (ACC_W=16): W = -128, 2 beats of a = -128 (2 x 16384) → 0x8000 (-32768) without SPARSE_TILE_ACC_SAT_EN; 0x7FFF (32767) with it.
5. Reset mid-COMPUTE: assert rst_n=0 after 2 beats; then run scenario 1 again → identical result (6), with no residue and weights re-loaded.
6. Protocol edges: start pulsed during LOAD/COMPUTE is ignored; a single beat with act_zero=1 and act_last=1 → all accumulators read 0; wgt_valid asserted in COMPUTE is not accepted (wgt_ready=0).

Source files
------------

// File: rtl/sparse_systolic_tile.sv
// Weight-stationary sparse MAC tile: handshaked weight load, skewed activation stream, row-serial drain.
// Define SPARSE_TILE_ACC_SAT_EN for saturating accumulation; default build wraps modulo 2^ACC_W.
module sparse_systolic_tile #(
  parameter int N_ROWS = 16,
  parameter int N_COLS = 16,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        wgt_valid,
  output logic                        wgt_ready,
  input  logic [N_COLS*DATA_W-1:0]    wgt_data,
  input  logic                        act_valid,
  output logic                        act_ready,
  input  logic [N_ROWS*DATA_W-1:0]    act_data,
  input  logic                        act_zero,
  input  logic                        act_last,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [N_COLS*ACC_W-1:0]     res_data,
  output logic [((N_ROWS > 1) ? $clog2(N_ROWS) : 1)-1:0] res_row,
  output logic                        busy,
  output logic                        done
);
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, FLUSH, DRAIN} state_t;
  state_t state;

  logic [RW-1:0] load_ptr;
  logic [CW-1:0] flush_cnt;
  logic          act_fire;

  logic signed [DATA_W-1:0] wgt    [N_ROWS][N_COLS];
  // Element [c] of the activation/valid chains is the stage that feeds PE column c.
  logic signed [DATA_W-1:0] act_p0 [N_ROWS][N_COLS];
  logic        [N_COLS-1:0] vld_p0;
  logic signed [ACC_W-1:0]  acc    [N_ROWS][N_COLS];

  function automatic logic signed [2*DATA_W-1:0] mul(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] w);
    logic signed [2*DATA_W-1:0] ax, wx;
    ax = (2*DATA_W)'(a);
    wx = (2*DATA_W)'(w);
    return ax * wx;
  endfunction

  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [2*DATA_W-1:0] p);
`ifdef SPARSE_TILE_ACC_SAT_EN
    logic signed [ACC_W:0] sum;
    sum = (ACC_W+1)'(a) + (ACC_W+1)'(p);
    if (sum[ACC_W] != sum[ACC_W-1])
      return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return sum[ACC_W-1:0];
`else
    return a + ACC_W'(p);
`endif
  endfunction

  assign wgt_ready = (state == LOAD);
  assign act_ready = (state == COMPUTE);
  assign res_valid = (state == DRAIN);
  assign busy      = (state != IDLE);
  assign act_fire  = act_valid & act_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      load_ptr  <= '0;
      flush_cnt <= '0;
      res_row   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= LOAD;
          load_ptr <= '0;
        end
        LOAD: if (wgt_valid) begin
          if (load_ptr == RW'(N_ROWS-1)) begin
            load_ptr <= '0;
            state    <= COMPUTE;
          end else begin
            load_ptr <= load_ptr + 1'b1;
          end
        end
        COMPUTE: if (act_fire && act_last) begin
          state     <= FLUSH;
          flush_cnt <= '0;
        end
        FLUSH: begin
          if (flush_cnt == CW'(N_COLS-1)) begin
            state   <= DRAIN;
            res_row <= '0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        DRAIN: if (res_ready) begin
          if (res_row == RW'(N_ROWS-1)) begin
            state   <= IDLE;
            res_row <= '0;
            done    <= 1'b1;
          end else begin
            res_row <= res_row + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N_ROWS; r++)
        for (int c = 0; c < N_COLS; c++)
          wgt[r][c] <= '0;
    end else if (state == LOAD && wgt_valid) begin
      for (int c = 0; c < N_COLS; c++)
        wgt[load_ptr][c] <= wgt_data[c*DATA_W +: DATA_W];
    end
  end

  // Stage boundary: injection into column 0, then one column of skew per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= '0;
      for (int r = 0; r < N_ROWS; r++)
        for (int c = 0; c < N_COLS; c++)
          act_p0[r][c] <= '0;
    end else begin
      vld_p0[0] <= act_fire & ~act_zero;
      for (int c = 1; c < N_COLS; c++)
        vld_p0[c] <= vld_p0[c-1];
      for (int r = 0; r < N_ROWS; r++) begin
        act_p0[r][0] <= act_data[r*DATA_W +: DATA_W];
        for (int c = 1; c < N_COLS; c++)
          act_p0[r][c] <= act_p0[r][c-1];
      end
    end
  end

  // Stage boundary: PE accumulate, one cycle after the operand reaches its column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N_ROWS; r++)
        for (int c = 0; c < N_COLS; c++)
          acc[r][c] <= '0;
    end else if (state == IDLE && start) begin
      for (int r = 0; r < N_ROWS; r++)
        for (int c = 0; c < N_COLS; c++)
          acc[r][c] <= '0;
    end else begin
      for (int r = 0; r < N_ROWS; r++)
        for (int c = 0; c < N_COLS; c++)
          if (vld_p0[c])
            acc[r][c] <= acc_add(acc[r][c], mul(act_p0[r][c], wgt[r][c]));
    end
  end

  always_comb begin
    res_data = '0;
    if (state == DRAIN)
      for (int c = 0; c < N_COLS; c++)
        res_data[c*ACC_W +: ACC_W] = acc[res_row][c];
  end
endmodule

// File: tb/tb_sparse_systolic_tile.sv
// Directed bench for sparse_systolic_tile: table of jobs plus hand sequences for reset,
// protocol edges and ACC_W=16 overflow (expectation follows SPARSE_TILE_ACC_SAT_EN).
module tb_sparse_systolic_tile;
  localparam int NR = 4, NC = 4, DW = 8, AW = 32, OW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start, wgt_valid, wgt_ready, act_valid, act_ready, act_zero, act_last;
  logic            res_valid, res_ready, busy, done;
  logic [NC*DW-1:0] wgt_data;
  logic [NR*DW-1:0] act_data;
  logic [NC*AW-1:0] res_data;
  logic [1:0]       res_row;

  logic            o_start, o_wgt_valid, o_wgt_ready, o_act_valid, o_act_ready, o_act_zero, o_act_last;
  logic            o_res_valid, o_res_ready, o_busy, o_done;
  logic [NC*DW-1:0] o_wgt_data;
  logic [NR*DW-1:0] o_act_data;
  logic [NC*OW-1:0] o_res_data;
  logic [1:0]       o_res_row;

  sparse_systolic_tile #(.N_ROWS(NR), .N_COLS(NC), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_data(wgt_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .act_zero(act_zero), .act_last(act_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_row(res_row),
    .busy(busy), .done(done));

  sparse_systolic_tile #(.N_ROWS(NR), .N_COLS(NC), .DATA_W(DW), .ACC_W(OW)) u_ovf (
    .clk(clk), .rst_n(rst_n), .start(o_start),
    .wgt_valid(o_wgt_valid), .wgt_ready(o_wgt_ready), .wgt_data(o_wgt_data),
    .act_valid(o_act_valid), .act_ready(o_act_ready), .act_data(o_act_data),
    .act_zero(o_act_zero), .act_last(o_act_last),
    .res_valid(o_res_valid), .res_ready(o_res_ready), .res_data(o_res_data), .res_row(o_res_row),
    .busy(o_busy), .done(o_done));

`ifdef SPARSE_TILE_ACC_SAT_EN
  localparam logic [OW-1:0] OVF_EXP = 16'h7FFF;
`else
  localparam logic [OW-1:0] OVF_EXP = 16'h8000;
`endif

  typedef struct {
    int              wmode;      // 0: W=1, 1: W=r+c, 2: W=r-c
    logic signed [7:0] a;        // activation value
    bit              lane_scale; // lane r carries a*(r+1)
    int              nbeats;
    logic [7:0]      zmask;      // bit b: beat b is a zero block (data 7)
    int              k;          // acc[r][c] = k * scale(r) * W[r][c]
    logic [15:0]     rdy_pat;    // res_ready per drain cycle
    bit              gap;        // idle cycle between beats
  } job_t;

  job_t jobs[5];
  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int wval(input int mode, input int r, input int c);
    case (mode)
      0: return 1;
      1: return r + c;
      2: return r - c;
      default: return 0;
    endcase
  endfunction

  function automatic logic [127:0] exp_row(input job_t j, input int r);
    logic [127:0] row;
    int v;
    row = '0;
    for (int c = 0; c < NC; c++) begin
      v = j.k * (j.lane_scale ? r + 1 : 1) * wval(j.wmode, r, c);
      row[c*AW +: AW] = v;
    end
    return row;
  endfunction

  task automatic start_job;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("wgt_ready_load", wgt_ready, 1);
  endtask

  task automatic load_w(input int mode, input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      wgt_valid = 1'b1;
      for (int c = 0; c < NC; c++) wgt_data[c*DW +: DW] = 8'(wval(mode, r, c));
      tick;
    end
    wgt_valid = 1'b0;
  endtask

  task automatic stream(input job_t j);
    for (int b = 0; b < j.nbeats; b++) begin
      if (j.gap && b > 0) begin
        act_valid = 1'b0;
        tick;
      end
      act_valid = 1'b1;
      act_zero  = j.zmask[b];
      act_last  = (b == j.nbeats - 1);
      for (int r = 0; r < NR; r++)
        act_data[r*DW +: DW] = j.zmask[b] ? 8'sd7 : 8'(j.a * (j.lane_scale ? r + 1 : 1));
      if (b == 0) check("act_ready_compute", act_ready, 1);
      tick;
    end
    act_valid = 1'b0;
    act_zero  = 1'b0;
    act_last  = 1'b0;
  endtask

  task automatic flush_and_drain(input job_t j);
    int fl, row, cyc;
    fl = 0;
    while (!res_valid && fl < 20) begin
      check("act_ready_flush", act_ready, 0);
      fl++;
      tick;
    end
    check("flush_len", fl, NC);
    row = 0;
    cyc = 0;
    while (row < NR && cyc < 40) begin
      check("res_valid", res_valid, 1);
      check("res_row", res_row, row);
      check("res_data", res_data, exp_row(j, row));
      res_ready = j.rdy_pat[cyc % 16];
      tick;
      if (res_ready) row++;
      cyc++;
    end
    res_ready = 1'b0;
    if (row < NR) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d rows expected %0d", row, NR);
    end
    check("done_pulse", done, 1);
    check("busy_falls", busy, 0);
    check("res_valid_idle", res_valid, 0);
    check("res_data_idle", res_data, 0);
    tick;
    check("done_single", done, 0);
  endtask

  task automatic run_job(input job_t j);
    start_job;
    load_w(j.wmode, 0, NR - 1);
    stream(j);
    flush_and_drain(j);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    job_t pj;
    int ow;
    start = 0; wgt_valid = 0; wgt_data = '0; act_valid = 0; act_data = '0;
    act_zero = 0; act_last = 0; res_ready = 0;
    o_start = 0; o_wgt_valid = 0; o_wgt_data = '0; o_act_valid = 0; o_act_data = '0;
    o_act_zero = 0; o_act_last = 0; o_res_ready = 0;

    jobs[0] = '{wmode: 0, a: 8'sd2,  lane_scale: 0, nbeats: 3, zmask: 8'h00, k: 6,
                rdy_pat: 16'hFFFF, gap: 0};
    jobs[1] = '{wmode: 1, a: 8'sd3,  lane_scale: 0, nbeats: 5, zmask: 8'h0A, k: 9,
                rdy_pat: 16'b1001_0110_1100_1001, gap: 1};
    jobs[2] = '{wmode: 1, a: -8'sd5, lane_scale: 0, nbeats: 2, zmask: 8'h00, k: -10,
                rdy_pat: 16'hFFFF, gap: 0};
    jobs[3] = '{wmode: 0, a: 8'sd7,  lane_scale: 0, nbeats: 1, zmask: 8'h01, k: 0,
                rdy_pat: 16'b0101_0101_0101_0101, gap: 0};
    jobs[4] = '{wmode: 2, a: -8'sd4, lane_scale: 1, nbeats: 4, zmask: 8'h04, k: -12,
                rdy_pat: 16'b0011_0011_0011_0011, gap: 0};

    // Reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_wgt_ready", wgt_ready, 0);
    check("rst_act_ready", act_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_done", done, 0);
    tick;
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 5; i++) run_job(jobs[i]);

    // Reset in the middle of COMPUTE, then a clean job must give the basic result
    start_job;
    load_w(1, 0, NR - 1);
    act_valid = 1'b1;
    act_data = {4{8'sd9}};
    tick;
    tick;
    act_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_act_ready", act_ready, 0);
    check("midrst_res_data", res_data, 0);
    tick;
    rst_n = 1'b1;
    tick;
    run_job(jobs[0]);

    // start during LOAD/COMPUTE and wgt_valid during COMPUTE are ignored
    pj = '{wmode: 0, a: 8'sd1, lane_scale: 0, nbeats: 1, zmask: 8'h00, k: 1,
           rdy_pat: 16'hFFFF, gap: 0};
    start_job;
    load_w(0, 0, 1);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("start_in_load_ignored", wgt_ready, 1);
    load_w(0, 2, NR - 1);
    check("compute_after_load", act_ready, 1);
    wgt_valid = 1'b1;
    wgt_data = {4{8'h55}};
    start = 1'b1;
    check("wgt_ready_compute", wgt_ready, 0);
    tick;
    wgt_valid = 1'b0;
    start = 1'b0;
    check("start_in_compute_ignored", act_ready, 1);
    stream(pj);
    flush_and_drain(pj);

    // ACC_W=16 overflow: two products of 16384
    o_start = 1'b1;
    tick;
    o_start = 1'b0;
    for (int r = 0; r < NR; r++) begin
      o_wgt_valid = 1'b1;
      o_wgt_data = {4{8'h80}};
      tick;
    end
    o_wgt_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      o_act_valid = 1'b1;
      o_act_data = {4{8'h80}};
      o_act_last = (b == 1);
      tick;
    end
    o_act_valid = 1'b0;
    o_act_last = 1'b0;
    ow = 0;
    while (!o_res_valid && ow < 20) begin
      ow++;
      tick;
    end
    check("ovf_flush_len", ow, NC);
    for (int r = 0; r < NR; r++) begin
      check("ovf_res_row", o_res_row, r);
      check("ovf_res_data", o_res_data, {4{OVF_EXP}});
      o_res_ready = 1'b1;
      tick;
    end
    o_res_ready = 1'b0;
    check("ovf_done", o_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
